// File: rtl/vec_pkg.sv
// Shared types and sizes for the vector load/store datapath.
// Lane 0 of a memory sequence is the most-significant byte of the vector.
package vec_pkg;

    localparam int NUM_LANES  = 16;
    localparam int LANE_W     = 8;
    localparam int WORD_W     = 32;
    localparam int LANE_IDX_W = $clog2(NUM_LANES);

    typedef logic [LANE_W-1:0]                 lane_t;
    typedef logic [NUM_LANES-1:0][LANE_W-1:0]  vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } store_state_t;

endpackage

// File: rtl/vec_store_seq_lane_sel.sv
// Lane selector: picks memory-order lane idx (MSB-first) and zero-extends it to a word.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Shared with the vector load/store blocks, so it sizes itself from vec_pkg.
module lane_sel
    import vec_pkg::*;
(
    input  vec_t                    vec,
    input  logic [LANE_IDX_W-1:0]   idx,
    output logic [WORD_W-1:0]       word
);

    logic [LANE_IDX_W-1:0] pos;

    // Memory lane 0 maps to the top packed element of the vector.
    always_comb begin
        pos  = LANE_IDX_W'(NUM_LANES - 1) - idx;
        word = WORD_W'(vec[pos]);
    end

endmodule

// File: rtl/vec_store_seq.sv
// Stores a SIMD result vector as NUM_LANES zero-extended words, one per accepted write.
// Latency: first write 1 cycle after start, done 1 cycle after the last accepted write.
// Backpressure: mem_ready=0 holds the registered write indefinitely; busy stalls the pipeline.
module vec_store_seq #(
    parameter int NUM_LANES = vec_pkg::NUM_LANES,
    parameter int LANE_W    = vec_pkg::LANE_W,
    parameter int WORD_W    = vec_pkg::WORD_W,
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [NUM_LANES*LANE_W-1:0]   ResultV,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [WORD_W-1:0]             mem_wdata,
    input  logic                          mem_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W = $clog2(NUM_LANES);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_LANES - 1);

    vec_pkg::store_state_t              state;
    logic [IDX_W-1:0]                   lane;
    logic [IDX_W-1:0]                   lane_nxt;
    logic [NUM_LANES-1:0][LANE_W-1:0]   vec_q;
    logic [ADDR_W-1:0]                  base_q;

    logic [NUM_LANES-1:0][LANE_W-1:0]   sel_vec;
    logic [IDX_W-1:0]                   sel_idx;
    logic [WORD_W-1:0]                  sel_word;
    logic [ADDR_W-1:0]                  next_addr;

    // In IDLE the selector looks at the live input so lane 0 can be registered
    // in the same edge that captures the vector; afterwards it looks one lane ahead.
    always_comb begin
        lane_nxt  = lane + 1'b1;
        sel_vec   = vec_q;
        sel_idx   = lane_nxt;
        if (state == vec_pkg::IDLE) begin
            sel_vec = ResultV;
            sel_idx = '0;
        end
        next_addr = base_q + ADDR_W'(lane_nxt) * ADDR_W'(ADDR_STEP);
    end

    lane_sel u_lane_sel (
        .vec  (sel_vec),
        .idx  (sel_idx),
        .word (sel_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= vec_pkg::IDLE;
            lane      <= '0;
            vec_q     <= '0;
            base_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                vec_pkg::IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        vec_q     <= ResultV;
                        base_q    <= base_addr;
                        lane      <= '0;
                        mem_we    <= 1'b1;
                        mem_addr  <= base_addr;
                        mem_wdata <= sel_word;
                        busy      <= 1'b1;
                        state     <= vec_pkg::WRITE;
                    end
                end

                vec_pkg::WRITE: begin
                    if (mem_ready) begin
                        if (lane == LAST_LANE) begin
                            mem_we <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= vec_pkg::DONE;
                        end else begin
                            lane      <= lane_nxt;
                            mem_addr  <= next_addr;
                            mem_wdata <= sel_word;
                        end
                    end
                end

                vec_pkg::DONE: begin
                    done  <= 1'b0;
                    state <= vec_pkg::IDLE;
                end

                default: begin
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= vec_pkg::IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_store_seq.sv
// Directed bench for vec_store_seq: reset, full store, wait states, ignored start,
// mid-store reset, address wrap and back-to-back stores.
module tb_vec_store_seq;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [31:0]   base_addr;
    logic [127:0]  ResultV;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic          busy;
    logic          done;

    int tests  = 0;
    int failed = 0;

    localparam logic [127:0] V1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] V2 = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;

    vec_store_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .ResultV   (ResultV),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_we"},   32'(mem_we), 32'd0);
        chk({tag, "_busy"}, 32'(busy),   32'd0);
        chk({tag, "_done"}, 32'(done),   32'd0);
    endtask

    // Issues a store at the current negedge and checks every write cycle.
    // stall_lane holds mem_ready low for stall_n cycles on that lane;
    // inject_lane pulses a competing start with different data/address.
    task automatic run_store(input logic [31:0] base, input logic [127:0] v,
                             input int stall_lane, input int stall_n, input int inject_lane);
        logic [31:0] ea;
        logic [31:0] ed;
        int          hold;
        start     = 1'b1;
        base_addr = base;
        ResultV   = v;
        mem_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            ea   = base + 32'(k * 4);
            ed   = {24'h0, v[127 - 8*k -: 8]};
            hold = (k == stall_lane) ? stall_n : 0;
            for (int w = 0; w <= hold; w++) begin
                start = (k == inject_lane) && (w == 0);
                if (start) begin
                    ResultV   = ~v;
                    base_addr = ~base;
                end
                mem_ready = (w == hold);
                chk("wr_we",   32'(mem_we), 32'd1);
                chk("wr_addr", mem_addr,    ea);
                chk("wr_data", mem_wdata,   ed);
                chk("wr_busy", 32'(busy),   32'd1);
                chk("wr_done", 32'(done),   32'd0);
                @(negedge clk);
            end
        end
        start     = 1'b0;
        mem_ready = 1'b1;
        chk("done_pulse", 32'(done),   32'd1);
        chk("done_we",    32'(mem_we), 32'd0);
        chk("done_busy",  32'(busy),   32'd0);
        @(negedge clk);
        chk_idle("after_done");
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = 32'h0;
        ResultV   = '0;
        mem_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_addr", mem_addr,  32'h0);
        chk("rst_data", mem_wdata, 32'h0);
        chk_idle("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle("post_rst");
        end

        // Full store, no wait states: 0x100..0x13C, bytes 00,11,...,FF
        run_store(32'h0000_0100, V1, -1, 0, -1);

        // Four wait states on lane 3 (addr 0x10C, data 0x33 held five cycles)
        run_store(32'h0000_0100, V1, 3, 4, -1);

        // Competing start during lane 7 must not disturb this store or queue another
        run_store(32'h0000_0100, V1, -1, 0, 7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle("no_second_store");
        end

        // Reset at lane 9 aborts the store asynchronously
        start     = 1'b1;
        base_addr = 32'h0000_0300;
        ResultV   = V1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("lane9_addr", mem_addr,  32'h0000_0324);
        chk("lane9_data", mem_wdata, 32'h0000_0099);
        rst_n = 1'b0;
        #1;
        chk("async_we",   32'(mem_we), 32'd0);
        chk("async_busy", 32'(busy),   32'd0);
        chk("async_addr", mem_addr,    32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle("abort_idle");
        end
        run_store(32'h0000_0400, V1, -1, 0, -1);

        // Address wrap, then a store started in the first IDLE cycle after done
        run_store(32'hFFFF_FFF8, V2, -1, 0, -1);
        run_store(32'h0000_0040, V1, 10, 2, -1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vec_store_seq.md
Name: vec_store_seq

Overview:
- Sequences a 128-bit SIMD result vector into data memory as 16 zero-extended 32-bit words, one write per accepted memory cycle.
- Sits between the vector execute/writeback stage and the data-memory write port.
- Stalls the pipeline while a store is in flight.
- Lane order is fixed: memory word k receives byte ResultV[127-8k -: 8], so word 0 holds the most-significant byte.

Parameters:
- NUM_LANES, 16, number of byte lanes per vector; vector width = NUM_LANES*LANE_W.
- LANE_W, 8, width of one lane in bits.
- WORD_W, 32, memory data width; lanes are zero-extended to this width.
- ADDR_W, 32, memory address width.
- ADDR_STEP, 4, address increment between consecutive lane words (byte addressing).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to store the vector; sampled only in IDLE.
- base_addr  in  ADDR_W  address of lane-word 0; captured with start.
- ResultV  in  NUM_LANES*LANE_W  vector to store; captured with start.
- mem_we  out  1  write strobe to data memory.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  WORD_W  write data (zero-extended lane).
- mem_ready  in  1  memory accepts the current write this cycle when mem_we=1 and mem_ready=1.
- busy  out  1  high from the cycle after an accepted start until done; used as pipeline stall.
- done  out  1  one-cycle pulse after the last lane write is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
  - Lane counter=0; captured vector and address cleared.
  - Reset mid-store aborts immediately. Remaining lanes are not written; no done pulse.
- States: IDLE, WRITE, DONE.
- IDLE:
  - On start=1, register ResultV and base_addr, set lane=0, go to WRITE.
  - start in any other state is ignored. No queuing.
- WRITE:
  - mem_we=1, mem_addr=base+lane*ADDR_STEP, mem_wdata={zeros, lane byte}.
  - All three outputs are registered and stable until accepted.
  - On mem_ready=1: if lane=NUM_LANES-1, go to DONE; otherwise lane+1 and the next address/data appear the following cycle.
  - On mem_ready=0: hold all outputs unchanged, with no limit on wait states.
- DONE:
  - done=1 and mem_we=0 for exactly one cycle, then IDLE.
  - busy=0 in DONE, so a new start is accepted the cycle after DONE, in IDLE.
- Latency: with mem_ready held high, the first write is issued 1 cycle after start. There are 16 consecutive write cycles, done is asserted on cycle 17 after start, and the store takes 18 cycles from start back to IDLE.
- Address arithmetic is modulo 2^ADDR_W. Wrap-around past all-ones is permitted and not flagged.
- The captured vector is immune to ResultV changes after the start cycle.
- busy=1 in WRITE only. busy=0 in IDLE and DONE.

Decomposition:
- Shared package vec_pkg:
  - NUM_LANES, LANE_W, WORD_W constants.
  - typedef lane_t (logic [LANE_W-1:0]).
  - typedef vec_t (logic [NUM_LANES-1:0][LANE_W-1:0]).
  - Enum store_state_t {IDLE, WRITE, DONE}.
- One sub-module, lane_sel: combinational mux selecting the lane byte by index with MSB-first ordering and zero-extending it to WORD_W. It is reused by future vector-load/store blocks.
- FSM, counter and address generator stay in the top module.

Test Plan:
- Reset values: hold rst_n=0 for 3 cycles, then release -> all outputs 0, state IDLE, and no mem_we after release until start.
- Full store, no wait states: ResultV=128'h00112233_44556677_8899AABB_CCDDEEFF, base_addr=32'h100, mem_ready=1 -> 16 writes at 0x100..0x13C.
  - First data 32'h00, second 32'h11, last 32'hFF.
  - busy high for 16 cycles, single done pulse on cycle 17.
- Wait states: same vector, mem_ready=0 on lane 3 for 4 cycles -> addr 0x10C and data 32'h33 held 5 cycles, no skipped or duplicated lane, done on cycle 21.
- Ignored start: pulse start with different ResultV and base_addr during lane 7 -> stored data and addresses unchanged, and no second store follows.
- Mid-operation reset: assert rst_n=0 at lane 9 -> mem_we falls asynchronously, no done. A new start after release begins again at lane 0 with the new base.
- Address wrap plus back-to-back stores: base_addr=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0, 4, ...; a start issued in the first IDLE cycle after done begins the next store immediately.
